// File: rtl/mp_adder_arbiter_pkg.sv
// Shared constants for the mp_adder round-robin sequencer: FSM state encodings and
// the requester index width helper.
package mp_adder_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_LAUNCH = 2'd1;
  localparam state_t S_WAIT   = 2'd2;
  localparam state_t S_RESP   = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mp_adder_arbiter_rr_arbiter.sv
// Combinational round-robin winner select: the first asserted request at or after the
// pointer, wrapping past NUM_REQ-1 back to 0. Returns a one-hot grant and its index.
module mp_adder_arbiter_rr_arbiter
  import mp_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  int unsigned     cand;
  logic [IW-1:0]   cand_idx;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Scan farthest-first so the last hit, the one closest to the pointer, wins.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand     = (32'(ptr_i) + 32'(off)) % 32'(NUM_REQ);
      cand_idx = IW'(cand);
      if (req_i[cand_idx]) begin
        gnt_o = ONE << cand_idx;
        idx_o = cand_idx;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mp_adder_arbiter.sv
// Round-robin sequencer sharing one mp_adder between NUM_REQ requesters.
// Define MP_ADDER_ARB_TIMEOUT_EN to add a WAIT-state watchdog that reports oErr.
module mp_adder_arbiter
  import mp_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int OPERAND_WIDTH  = 1024,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             iClk,
  input  logic                             iRst,
  input  logic [NUM_REQ-1:0]               iReq,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] iOpA,
  input  logic [NUM_REQ*OPERAND_WIDTH-1:0] iOpB,
  output logic [NUM_REQ-1:0]               oGnt,
  output logic [NUM_REQ-1:0]               oResValid,
  output logic [OPERAND_WIDTH:0]           oRes,
  output logic                             oErr,
  output logic                             oBusy,
  output logic                             oAddStart,
  output logic [OPERAND_WIDTH-1:0]         oAddOpA,
  output logic [OPERAND_WIDTH-1:0]         oAddOpB,
  input  logic [OPERAND_WIDTH:0]           iAddRes,
  input  logic                             iAddDone
);

  localparam int                 IW  = idx_width(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mp_adder_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES at least 1");
  end

  state_t                   state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            win_q, win_d;
  logic [OPERAND_WIDTH-1:0] op_a_q, op_a_d;
  logic [OPERAND_WIDTH-1:0] op_b_q, op_b_d;
  logic [OPERAND_WIDTH:0]   res_q, res_d;

  logic [NUM_REQ-1:0]       arb_gnt;
  logic [IW-1:0]            arb_idx;
  logic                     arb_any;
  logic [OPERAND_WIDTH-1:0] sel_a, sel_b;

`ifdef MP_ADDER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timeout;

  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

  mp_adder_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req_i (iReq),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // One-hot AND-OR operand mux driven by the arbiter grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_a |= iOpA[i*OPERAND_WIDTH +: OPERAND_WIDTH];
        sel_b |= iOpB[i*OPERAND_WIDTH +: OPERAND_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
`ifdef MP_ADDER_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          win_d   = arb_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
`ifdef MP_ADDER_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (iAddDone) begin
          res_d   = iAddRes;
`ifdef MP_ADDER_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
`ifdef MP_ADDER_ARB_TIMEOUT_EN
        else if (timeout) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_RESP: begin
        ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      // NOTE: the wide operand/result registers are cleared too, since they are visible outputs.
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
`ifdef MP_ADDER_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
`ifdef MP_ADDER_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // The grant is combinational in IDLE, so it must be masked while reset is held.
  assign oGnt      = (state_q == S_IDLE && !iRst) ? arb_gnt : '0;
  assign oResValid = (state_q == S_RESP) ? (ONE << win_q) : '0;
  assign oRes      = res_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oAddStart = (state_q == S_LAUNCH);
  assign oAddOpA   = op_a_q;
  assign oAddOpB   = op_b_q;
`ifdef MP_ADDER_ARB_TIMEOUT_EN
  assign oErr      = err_q;
`else
  assign oErr      = 1'b0;
`endif

endmodule

// File: tb/tb_mp_adder_arbiter.sv
// Scoreboard bench for mp_adder_arbiter with a behavioural mp_adder stand-in.
// Define MP_ADDER_ARB_TIMEOUT_EN to also exercise the watchdog path.
module tb_mp_adder_arbiter;

  localparam int N              = 4;
  localparam int W              = 1024;
  localparam int TIMEOUT_CYCLES = 64;

  typedef struct {
    logic [N-1:0] vld;
    logic [W:0]   sum;
    logic         err;
  } exp_t;

  logic             iClk = 1'b0;
  logic             iRst;
  logic [N-1:0]     iReq;
  logic [N*W-1:0]   iOpA, iOpB;
  logic [N-1:0]     oGnt, oResValid;
  logic [W:0]       oRes;
  logic             oErr, oBusy, oAddStart;
  logic [W-1:0]     oAddOpA, oAddOpB;
  logic [W:0]       iAddRes;
  logic             iAddDone;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  int           ops_left [N];

  exp_t       sb[$];
  int         gnt_log[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         pend = -1;
  int         gnt_cyc = 0;
  int         exp_resp_cyc = 0;
  int         n_starts = 0;
  int         lat_fixed = 0;
  int         m_cnt = 0;
  bit         m_busy = 1'b0;
  bit         stall = 1'b0;
  bit         spur_done = 1'b0;
  logic [W:0] spur_res = '0;
  logic [W:0] last_sum = '0;

  assign iOpA = {opa[3], opa[2], opa[1], opa[0]};
  assign iOpB = {opb[3], opb[2], opb[1], opb[0]};

  mp_adder_arbiter #(
    .NUM_REQ        (N),
    .OPERAND_WIDTH  (W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iReq      (iReq),
    .iOpA      (iOpA),
    .iOpB      (iOpB),
    .oGnt      (oGnt),
    .oResValid (oResValid),
    .oRes      (oRes),
    .oErr      (oErr),
    .oBusy     (oBusy),
    .oAddStart (oAddStart),
    .oAddOpA   (oAddOpA),
    .oAddOpB   (oAddOpB),
    .iAddRes   (iAddRes),
    .iAddDone  (iAddDone)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got carry=%b low64=%h, expected carry=%b low64=%h",
               tag, got[W], got[63:0], exp[W], exp[63:0]);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: sample 1 time unit after the falling edge, then return on the next one.
  task automatic tick();
    int   gi;
    exp_t e;
    #1;
    cyc++;
    if (pend >= 0) begin
      opa[pend] = rand_op();
      opb[pend] = rand_op();
      if (ops_left[pend] == 0) iReq[pend] = 1'b0;
      pend = -1;
    end

    if (oGnt != '0) begin
      check("gnt_onehot", $countones(oGnt), 1);
      gi = 0;
      for (int k = 0; k < N; k++) if (oGnt[k]) gi = k;
      check("gnt_req_held", iReq[gi], 1);
      e.vld = N'(1) << gi;
      e.err = stall;
      e.sum = stall ? '0 : {1'b0, opa[gi]} + {1'b0, opb[gi]};
      sb.push_back(e);
      gnt_log.push_back(gi);
      if (ops_left[gi] > 0) ops_left[gi]--;
      pend    = gi;
      gnt_cyc = cyc;
    end

    if (oResValid != '0) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", oResValid, 0);
      end else begin
        e = sb.pop_front();
        check("resp_vld", oResValid, e.vld);
        check("resp_sum", oRes, e.sum);
        check("resp_err", oErr, e.err);
        check("resp_latency", cyc, exp_resp_cyc);
        last_sum = e.sum;
      end
    end

    // mp_adder stand-in: samples its operands when it finishes, one done pulse per start.
    iAddDone = spur_done;
    if (spur_done) iAddRes = spur_res;
    spur_done = 1'b0;
    if (m_busy) begin
      if (m_cnt <= 1) begin
        iAddRes      = {1'b0, oAddOpA} + {1'b0, oAddOpB};
        iAddDone     = 1'b1;
        m_busy       = 1'b0;
        exp_resp_cyc = cyc + 1;
      end else begin
        m_cnt--;
      end
    end
    if (oAddStart) begin
      n_starts++;
      check("start_latency", cyc, gnt_cyc + 1);
      if (stall) begin
        exp_resp_cyc = cyc + TIMEOUT_CYCLES + 1;
      end else begin
        m_busy = 1'b1;
        m_cnt  = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(4, 1));
      end
    end
    @(negedge iClk);
  endtask

  task automatic do_reset();
    iRst      = 1'b1;
    iReq      = '0;
    iAddDone  = 1'b0;
    spur_done = 1'b0;
    m_busy    = 1'b0;
    stall     = 1'b0;
    pend      = -1;
    lat_fixed = 0;
    n_starts  = 0;
    sb.delete();
    gnt_log.delete();
    for (int k = 0; k < N; k++) ops_left[k] = 0;
    repeat (2) tick();
    iRst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (iReq == '0 && sb.size() == 0 && !oBusy && !m_busy && pend < 0) break;
      tick();
    end
    check({tag, "_drained"}, (k < budget) ? 1 : 0, 1);
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check({tag, "_ngrants"}, gnt_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < gnt_log.size(); k++)
      check($sformatf("%s_grant%0d", tag, k), gnt_log[k], exp_q[k]);
  endtask

  task automatic wait_start(input string tag, input int target);
    int k;
    for (k = 0; k < 20; k++) begin
      if (n_starts == target) break;
      tick();
    end
    check({tag, "_started"}, (k < 20) ? 1 : 0, 1);
  endtask

  initial begin
    int starts_before;
    iRst     = 1'b1;
    iReq     = '1;
    iAddDone = 1'b0;
    iAddRes  = '0;
    for (int k = 0; k < N; k++) begin
      opa[k]      = rand_op();
      opb[k]      = rand_op();
      ops_left[k] = 0;
    end
    @(negedge iClk);
    repeat (3) tick();

    // Held reset: everything low even with all requests raised.
    check("rst_gnt", oGnt, 0);
    check("rst_resvalid", oResValid, 0);
    check("rst_busy", oBusy, 0);
    check("rst_start", oAddStart, 0);
    check("rst_err", oErr, 0);
    check("rst_res", oRes, 0);
    check("rst_opa", oAddOpA, 0);
    check("rst_opb", oAddOpB, 0);
    iReq = '0;
    iRst = 1'b0;
    tick();

    // Single requester, full carry-out.
    opa[0]      = '1;
    opb[0]      = '0;
    opb[0][0]   = 1'b1;
    ops_left[0] = 1;
    iReq        = 4'b0001;
    wait_idle("single", 40);
    check_order("single", '{0});
    check("single_res_hold", oRes, {1'b1, {W{1'b0}}});
    check("single_starts", n_starts, 1);

    // Two simultaneous requesters.
    do_reset();
    ops_left[0] = 1;
    ops_left[2] = 1;
    iReq        = 4'b0101;
    wait_idle("pair", 60);
    check_order("pair", '{0, 2});
    check("pair_starts", n_starts, 2);

    // All four held for two ops each.
    do_reset();
    for (int k = 0; k < N; k++) ops_left[k] = 2;
    iReq = '1;
    wait_idle("all", 200);
    check_order("all", '{0, 1, 2, 3, 0, 1, 2, 3});
    check("all_starts", n_starts, 8);

    // Request pulsed while busy and dropped before grant is never served.
    do_reset();
    lat_fixed   = 8;
    ops_left[0] = 1;
    iReq        = 4'b0001;
    wait_start("drop", 1);
    iReq[1] = 1'b1;
    tick();
    iReq[1] = 1'b0;
    wait_idle("drop", 40);
    check_order("drop", '{0});

    // Done pulse while idle is ignored.
    starts_before = n_starts;
    spur_res      = {1'b1, rand_op()};
    spur_done     = 1'b1;
    repeat (4) tick();
    check("spur_busy", oBusy, 0);
    check("spur_res_hold", oRes, last_sum);
    check("spur_no_start", n_starts, starts_before);

    // Reset while waiting on the adder.
    do_reset();
    lat_fixed   = 20;
    ops_left[0] = 1;
    iReq        = 4'b0001;
    wait_start("midrst", 1);
    repeat (2) tick();
    #2;
    iRst = 1'b1;
    #1;
    check("midrst_busy", oBusy, 0);
    check("midrst_start", oAddStart, 0);
    check("midrst_resvalid", oResValid, 0);
    check("midrst_gnt", oGnt, 0);
    check("midrst_res", oRes, 0);
    check("midrst_opa", oAddOpA, 0);
    sb.delete();
    gnt_log.delete();
    pend      = -1;
    lat_fixed = 0;
    @(negedge iClk);
    repeat (2) tick();
    iRst = 1'b0;
    for (int k = 0; k < 40 && m_busy; k++) tick();
    check("midrst_stale_done_sent", m_busy, 0);
    repeat (3) tick();
    check("midrst_stale_busy", oBusy, 0);
    check("midrst_stale_res", oRes, 0);
    ops_left[1] = 1;
    iReq        = 4'b0010;
    wait_idle("after_rst", 40);
    check_order("after_rst", '{1});

`ifdef MP_ADDER_ARB_TIMEOUT_EN
    // Adder never answers: watchdog returns zero with the error flag.
    do_reset();
    stall       = 1'b1;
    ops_left[2] = 1;
    iReq        = 4'b0100;
    wait_idle("timeout", TIMEOUT_CYCLES + 20);
    check_order("timeout", '{2});
    stall = 1'b0;
    ops_left[3] = 1;
    iReq        = 4'b1000;
    wait_idle("post_timeout", 40);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
